// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with saturating direction
// counters and saturating performance counters.
//
// Ports:
//   clk_i, rst_i        clock; asynchronous active-high reset
//   lookup_pc_i         fetch PC, looked up combinationally
//   pred_hit_o          valid entry with matching tag at the lookup index
//   pred_taken_o        hit and direction counter MSB set
//   pred_npc_o          stored target when predicted taken, else lookup_pc_i + 4
//   upd_valid_i         one resolved control-flow instruction this cycle
//   upd_pc_i            PC of the resolved instruction
//   upd_taken_i         actual outcome
//   upd_target_i        actual target when taken
//   upd_mispredict_i    mispredict flag, qualified by upd_valid_i
//   clear_i             synchronous invalidate of every entry
//   perf_updates_o      saturating count of accepted updates
//   perf_mispredicts_o  saturating count of mispredicting updates
module branch_predictor #(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned CNT_W   = 2,
   parameter int unsigned PERF_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       lookup_pc_i,
   output logic              pred_hit_o,
   output logic              pred_taken_o,
   output logic [31:0]       pred_npc_o,
   input  logic              upd_valid_i,
   input  logic [31:0]       upd_pc_i,
   input  logic              upd_taken_i,
   input  logic [31:0]       upd_target_i,
   input  logic              upd_mispredict_i,
   input  logic              clear_i,
   output logic [PERF_W-1:0] perf_updates_o,
   output logic [PERF_W-1:0] perf_mispredicts_o
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = 30 - IDX_W;
   localparam logic [CNT_W-1:0] CtrMax  = '1;
   // Weakly taken: only the MSB set (for CNT_W=1 this is simply 1).
   localparam logic [CNT_W-1:0] CtrWeak = CNT_W'(1) << (CNT_W - 1);

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [31:0]        target_d [ENTRIES];
   logic [CNT_W-1:0]   ctr_q    [ENTRIES];
   logic [CNT_W-1:0]   ctr_d    [ENTRIES];

   logic [PERF_W-1:0] perf_upd_q, perf_upd_d;
   logic [PERF_W-1:0] perf_mis_q, perf_mis_d;

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             up_hit;

   assign lk_idx = lookup_pc_i[IDX_W+1:2];
   assign lk_tag = lookup_pc_i[31:IDX_W+2];
   assign up_idx = upd_pc_i[IDX_W+1:2];
   assign up_tag = upd_pc_i[31:IDX_W+2];
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   // Lookup reads registered state only, so a same-cycle update is not bypassed.
   always_comb begin
      pred_hit_o   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken_o = pred_hit_o && ctr_q[lk_idx][CNT_W-1];
      pred_npc_o   = pred_taken_o ? target_q[lk_idx] : (lookup_pc_i + 32'd4);
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (clear_i) begin
         valid_d = '0;
      end else if (upd_valid_i) begin
         if (up_hit) begin
            if (upd_taken_i) begin
               target_d[up_idx] = upd_target_i;
               if (ctr_q[up_idx] != CtrMax) ctr_d[up_idx] = ctr_q[up_idx] + 1'b1;
            end else if (ctr_q[up_idx] != '0) begin
               ctr_d[up_idx] = ctr_q[up_idx] - 1'b1;
            end
         end else if (upd_taken_i) begin
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = upd_target_i;
            ctr_d[up_idx]    = CtrWeak;
         end
      end
   end

   // Perf counters count every update, even one suppressed by clear_i.
   always_comb begin
      perf_upd_d = perf_upd_q;
      perf_mis_d = perf_mis_q;
      if (upd_valid_i && (perf_upd_q != '1)) perf_upd_d = perf_upd_q + 1'b1;
      if (upd_valid_i && upd_mispredict_i && (perf_mis_q != '1)) begin
         perf_mis_d = perf_mis_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q    <= '0;
         perf_upd_q <= '0;
         perf_mis_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= '0;
         end
      end else begin
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         target_q   <= target_d;
         ctr_q      <= ctr_d;
         perf_upd_q <= perf_upd_d;
         perf_mis_q <= perf_mis_d;
      end
   end

   assign perf_updates_o     = perf_upd_q;
   assign perf_mispredicts_o = perf_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a default build plus a PERF_W=4 build
// driven by the same stimulus.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] lookup_pc = 32'h0;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = 32'h0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = 32'h0;
   logic        upd_mis = 1'b0;
   logic        clr = 1'b0;

   logic        hit, tkn, hit4, tkn4;
   logic [31:0] npc, npc4, pu, pm;
   logic [3:0]  pu4, pm4;

   int checks = 0;
   int errors = 0;
   int cu = 0;
   int cm = 0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc),
      .pred_hit_o(hit), .pred_taken_o(tkn), .pred_npc_o(npc),
      .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
      .upd_target_i(upd_target), .upd_mispredict_i(upd_mis), .clear_i(clr),
      .perf_updates_o(pu), .perf_mispredicts_o(pm)
   );

   branch_predictor #(.PERF_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc),
      .pred_hit_o(hit4), .pred_taken_o(tkn4), .pred_npc_o(npc4),
      .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
      .upd_target_i(upd_target), .upd_mispredict_i(upd_mis), .clear_i(clr),
      .perf_updates_o(pu4), .perf_mispredicts_o(pm4)
   );

   typedef struct {
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utg;
      logic        um;
      logic [31:0] lpc;
      logic        eh;
      logic        et;
      logic [31:0] enpc;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic [31:0] utg,
                               logic um, logic [31:0] lpc, logic eh, logic et,
                               logic [31:0] enpc);
      vec_t v;
      v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg; v.um = um;
      v.lpc = lpc; v.eh = eh; v.et = et; v.enpc = enpc;
      return v;
   endfunction

   function automatic logic [31:0] sat4(int c);
      return (c > 15) ? 32'd15 : 32'(c);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_perf(string name);
      chk({name, " perf_updates"}, pu, 32'(cu));
      chk({name, " perf_mispredicts"}, pm, 32'(cm));
      chk({name, " perf_updates(4b)"}, {28'h0, pu4}, sat4(cu));
      chk({name, " perf_mispredicts(4b)"}, {28'h0, pm4}, sat4(cm));
   endtask

   task automatic chk_look(string name, logic eh, logic et, logic [31:0] enpc);
      chk({name, " pred_hit"}, {31'h0, hit}, {31'h0, eh});
      chk({name, " pred_taken"}, {31'h0, tkn}, {31'h0, et});
      chk({name, " pred_npc"}, npc, enpc);
   endtask

   task automatic idle();
      upd_valid = 1'b0; upd_taken = 1'b0; upd_mis = 1'b0; clr = 1'b0;
   endtask

   task automatic model_step();
      if (upd_valid) begin
         cu++;
         if (upd_mis) cm++;
      end
   endtask

   initial begin
      // Index 0 is shared by 0x40 and 0x80 (ENTRIES=16); 0x1044 maps to index 1.
      vecs[0]  = mk(0, 32'h0,    0, 32'h0,    0, 32'h40,   0, 0, 32'h44);
      vecs[1]  = mk(1, 32'h40,   1, 32'h100,  1, 32'h40,   0, 0, 32'h44);
      vecs[2]  = mk(0, 32'h0,    0, 32'h0,    0, 32'h40,   1, 1, 32'h100);
      vecs[3]  = mk(0, 32'h0,    0, 32'h0,    0, 32'h80,   0, 0, 32'h84);
      vecs[4]  = mk(1, 32'h40,   0, 32'h0,    1, 32'h40,   1, 1, 32'h100);
      vecs[5]  = mk(1, 32'h40,   0, 32'h0,    0, 32'h40,   1, 0, 32'h44);
      vecs[6]  = mk(1, 32'h40,   0, 32'h0,    1, 32'h40,   1, 0, 32'h44);
      vecs[7]  = mk(1, 32'h40,   0, 32'h0,    0, 32'h40,   1, 0, 32'h44);
      vecs[8]  = mk(1, 32'h40,   1, 32'h200,  1, 32'h40,   1, 0, 32'h44);
      vecs[9]  = mk(1, 32'h40,   1, 32'h200,  0, 32'h40,   1, 0, 32'h44);
      vecs[10] = mk(1, 32'h40,   1, 32'h200,  0, 32'h40,   1, 1, 32'h200);
      vecs[11] = mk(1, 32'h40,   1, 32'h200,  0, 32'h40,   1, 1, 32'h200);
      vecs[12] = mk(1, 32'h40,   0, 32'h0,    1, 32'h40,   1, 1, 32'h200);
      vecs[13] = mk(1, 32'h40,   0, 32'h0,    0, 32'h40,   1, 1, 32'h200);
      vecs[14] = mk(0, 32'h0,    0, 32'h0,    0, 32'h40,   1, 0, 32'h44);
      vecs[15] = mk(1, 32'h80,   0, 32'h0,    1, 32'h80,   0, 0, 32'h84);
      vecs[16] = mk(1, 32'h80,   1, 32'h300,  1, 32'h40,   1, 0, 32'h44);
      vecs[17] = mk(0, 32'h0,    0, 32'h0,    0, 32'h80,   1, 1, 32'h300);
      vecs[18] = mk(0, 32'h0,    0, 32'h0,    0, 32'h40,   0, 0, 32'h44);
      vecs[19] = mk(1, 32'h1044, 1, 32'h2000, 0, 32'h1044, 0, 0, 32'h1048);
      vecs[20] = mk(0, 32'h0,    0, 32'h0,    0, 32'h1044, 1, 1, 32'h2000);

      // Reset state.
      lookup_pc = 32'h40;
      #1;
      chk_look("reset", 1'b0, 1'b0, 32'h44);
      chk_perf("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
         upd_target = vecs[i].utg; upd_mis = vecs[i].um; lookup_pc = vecs[i].lpc;
         #1;
         chk_look($sformatf("vec%0d", i), vecs[i].eh, vecs[i].et, vecs[i].enpc);
         chk_perf($sformatf("vec%0d", i));
         model_step();
      end

      // Asynchronous reset in the middle of an update: update lost, table cleared.
      @(negedge clk);
      upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'h700;
      upd_mis = 1'b1; lookup_pc = 32'h80;
      #1;
      chk_look("pre-rst", 1'b1, 1'b1, 32'h300);
      rst = 1'b1;
      cu = 0; cm = 0;
      #1;
      chk_look("async-rst", 1'b0, 1'b0, 32'h84);
      chk_perf("async-rst");
      @(negedge clk);
      rst = 1'b0;
      idle();
      lookup_pc = 32'h1044;
      #1;
      chk_look("post-rst 0x1044", 1'b0, 1'b0, 32'h1048);

      // Clear beats a simultaneous update, but the update is still counted.
      upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
      upd_mis = 1'b0;
      @(negedge clk);
      model_step();
      upd_pc = 32'h1044; upd_target = 32'h2000;
      @(negedge clk);
      model_step();
      lookup_pc = 32'h40;
      #1;
      chk_look("pre-clear 0x40", 1'b1, 1'b1, 32'h100);
      clr = 1'b1; upd_pc = 32'h80; upd_target = 32'h900; upd_mis = 1'b1;
      @(negedge clk);
      model_step();
      idle();
      #1;
      chk_look("clear 0x40", 1'b0, 1'b0, 32'h44);
      chk_perf("clear");
      lookup_pc = 32'h80;
      #1;
      chk_look("clear 0x80", 1'b0, 1'b0, 32'h84);
      lookup_pc = 32'h1044;
      #1;
      chk_look("clear 0x1044", 1'b0, 1'b0, 32'h1048);

      // Perf counter saturation: 4-bit build must hold at 0xF.
      @(negedge clk);
      rst = 1'b1;
      cu = 0; cm = 0;
      @(negedge clk);
      rst = 1'b0;
      upd_valid = 1'b1; upd_pc = 32'hFFFFFFFC; upd_taken = 1'b0; upd_mis = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         model_step();
         if (i == 14) begin
            #1;
            chk_perf("sat15");
         end
      end
      idle();
      lookup_pc = 32'hFFFFFFFC;
      #1;
      chk_perf("sat16");
      chk_look("wrap npc", 1'b0, 1'b0, 32'h0);
      chk("wrap npc(4b)", npc4, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with saturating-counter direction prediction for the pipelined MIPS datapath. Sits beside the PC register: IF presents the fetch PC and receives a predicted next PC in the same cycle; the stage that resolves branches/jumps reports outcomes back to train the table. Adds speculative next-PC selection (the current pipeline always fetches PC+4 and redirects only on resolution) plus saturating performance counters.

## Interface
- ENTRIES, 16: table entries; power of two, >= 2; IDX_W = log2(ENTRIES).
- CNT_W, 2: direction counter width, >= 1.
- PERF_W, 32: performance counter width.
- Tag width is TAG_W = 30 - IDX_W, taken from pc[31:IDX_W+2].
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- lookup_pc  in  32  fetch PC (word aligned; bits [1:0] ignored).
- pred_hit  out  1  valid entry with matching tag at lookup index.
- pred_taken  out  1  pred_hit && counter MSB set.
- pred_npc  out  32  pred_taken ? stored target : lookup_pc + 4.
- upd_valid  in  1  one resolved control-flow instruction this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual outcome (jumps always 1).
- upd_target  in  32  actual target when taken.
- upd_mispredict  in  1  datapath-computed mispredict flag; sampled only with upd_valid.
- clear  in  1  synchronous invalidate of all entries.
- perf_updates  out  PERF_W  count of accepted updates.
- perf_mispredicts  out  PERF_W  count of updates with upd_mispredict.

## Operation
- Entry fields: valid, tag[TAG_W], target[32], ctr[CNT_W]. Index = pc[IDX_W+1:2].
- Lookup is purely combinational on lookup_pc against registered table state.
- Update (upd_valid=1, clear=0), entry e = table[idx(upd_pc)]:
  - Tag hit (e.valid and tags equal): ctr saturating +1 if taken, saturating -1 if not; target <= upd_target if taken, else unchanged.
  - Miss and taken: allocate/replace: valid=1, tag=upd_pc tag, target=upd_target, ctr = 2^(CNT_W-1) (weakly taken).
  - Miss and not taken: table unchanged.
- clear=1: all valid bits <= 0 next edge; clear wins over a simultaneous update (update not applied to table) but perf counters still count that update.
- perf_updates += 1 per upd_valid; perf_mispredicts += 1 per upd_valid && upd_mispredict; both saturate at all-ones, never wrap.
- Arithmetic: lookup_pc + 4 is modulo 2^32 (0xFFFFFFFC -> 0x00000000). Counter saturates at 0 and 2^CNT_W - 1.
- CNT_W=1: ctr MSB is the only bit; allocate sets it to 1.

## Timing
- Reset (RST high, asynchronous): all valid, ctr, target, tag <= 0; perf counters <= 0. Outputs during/after reset: pred_hit=0, pred_taken=0, pred_npc=lookup_pc+4, perf_*=0.
- Lookup latency 0 cycles (combinational). Update latency 1 cycle: visible to lookup from the cycle after the edge that samples upd_valid.
- Same-cycle lookup and update to the same index: lookup sees pre-update state (no bypass).
- Same-index aliasing: different tag replaces the entry on taken miss only.
- RST asserted mid-update: update discarded; table cleared.
- No handshake/backpressure: one update per cycle accepted unconditionally; datapath gates upd_valid with its own stall so a stalled instruction is reported exactly once.

## Test plan
- Reset then lookup_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_npc=0x00000044, perf_*=0.
- Update pc=0x40, taken, target=0x100; next cycle lookup 0x40 -> pred_hit=1, pred_taken=1, pred_npc=0x100, ctr=2; lookup 0x40+4*ENTRIES (alias) -> pred_hit=0.
- Four not-taken updates to 0x40 after allocation -> ctr 2->1->0->0, pred_taken=0 after first, pred_npc=0x44; three taken updates -> ctr saturates at 3, pred_taken=1.
- Same-cycle lookup and update at 0x80 (empty, taken) -> that cycle pred_hit=0; next cycle pred_hit=1.
- clear and upd_valid(taken, upd_mispredict=1) same cycle -> all lookups miss next cycle; perf_updates=1, perf_mispredicts=1.
- Force perf counters near max (PERF_W=4 build): 16 mispredicting updates -> both counters hold 0xF; lookup_pc=0xFFFFFFFC miss -> pred_npc=0x00000000.
